// File: rtl/rle_pkg.sv
// Shared constants and types for the run-length line encoder/decoder pair.
package rle_pkg;
   localparam int LEN_W    = 11;
   localparam int LINE_W   = 640;
   localparam int MAX_RUNS = 3;
   localparam int RIDX_W   = 2;

   typedef enum logic {S_WAIT_SOP, S_LINE} state_t;

   typedef logic [LEN_W-1:0] len_t;

   typedef struct packed {
      logic                     trunc;
      len_t [MAX_RUNS-1:0]      words;
   } line_t;
endpackage

// File: rtl/rle_out_hold.sv
// Line output register with valid/ready. Latency 1 cycle from line_vld to out_valid;
// a line completing while the held one is unaccepted is dropped and counted (saturating).
module rle_out_hold
   import rle_pkg::*;
(
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       line_vld,
   input  line_t      line_dat,
   input  logic       out_ready,
   output line_t      hold_dat,
   output logic       out_valid,
   output logic [7:0] drop_cnt
);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         hold_dat  <= '0;
         out_valid <= 1'b0;
         drop_cnt  <= '0;
      end else if (line_vld) begin
         // A handshake in the same cycle frees the slot for the new line
         if (!out_valid || out_ready) begin
            hold_dat  <= line_dat;
            out_valid <= 1'b1;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rle_line_encoder.sv
// Binary pixel stream to per-line run lengths (3 words, first run is symbol 0).
// Latency 1 cycle last pixel -> out_valid; lines finishing under backpressure are dropped.
module rle_line_encoder
   import rle_pkg::*;
(
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_sop,
   input  logic             out_ready,
   output logic [LEN_W-1:0] stream1,
   output logic [LEN_W-1:0] stream2,
   output logic [LEN_W-1:0] stream3,
   output logic             out_valid,
   output logic             new_im,
   output logic             trunc,
   output logic [7:0]       drop_cnt
);

   localparam len_t              LAST_X   = len_t'(LINE_W - 1);
   localparam len_t              ONE      = len_t'(1);
   localparam logic [RIDX_W-1:0] LAST_RUN = RIDX_W'(MAX_RUNS - 1);

   state_t              state, state_nxt;
   len_t                x, pix_x;
   len_t                len, n_len;
   logic [RIDX_W-1:0]   run_idx, n_idx;
   logic                cur_sym, n_sym;
   logic                trunc_acc, n_trunc;
   len_t [MAX_RUNS-1:0] acc, n_acc, fin;
   logic                take, first, last;
   line_t               line_dat, hold_dat;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state <= S_WAIT_SOP;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = in_valid && (in_sop || state == S_LINE);
      // The sop pixel is always pixel 0, aborting any partial line
      pix_x     = in_sop ? '0 : x;
      first     = (pix_x == '0);
      last      = take && (pix_x == LAST_X);
      if (take) state_nxt = S_LINE;
   end

   always_comb begin
      n_acc   = acc;
      n_idx   = run_idx;
      n_len   = len;
      n_sym   = cur_sym;
      n_trunc = trunc_acc;
      if (first) begin
         n_acc   = '0;
         n_trunc = 1'b0;
         n_len   = ONE;
         n_sym   = in_bit;
         n_idx   = in_bit ? RIDX_W'(1) : '0;
      end else if (in_bit == cur_sym) begin
         n_len = len + ONE;
      end else if (run_idx < LAST_RUN) begin
         n_acc[run_idx] = len;
         n_idx          = run_idx + RIDX_W'(1);
         n_sym          = ~cur_sym;
         n_len          = ONE;
      end else begin
         // Last word absorbs the remainder of the line
         n_len   = len + ONE;
         n_trunc = 1'b1;
      end
      fin            = n_acc;
      fin[n_idx]     = n_len;
      line_dat.trunc = n_trunc;
      line_dat.words = fin;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         x         <= '0;
         len       <= '0;
         run_idx   <= '0;
         cur_sym   <= 1'b0;
         trunc_acc <= 1'b0;
         acc       <= '0;
         new_im    <= 1'b0;
      end else begin
         new_im <= in_valid && in_sop;
         if (take) begin
            x         <= last ? '0 : pix_x + ONE;
            len       <= n_len;
            run_idx   <= n_idx;
            cur_sym   <= n_sym;
            trunc_acc <= n_trunc;
            acc       <= n_acc;
         end
      end
   end

   rle_out_hold u_hold (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .line_vld  (last),
      .line_dat  (line_dat),
      .out_ready (out_ready),
      .hold_dat  (hold_dat),
      .out_valid (out_valid),
      .drop_cnt  (drop_cnt)
   );

   assign stream1 = hold_dat.words[0];
   assign stream2 = hold_dat.words[1];
   assign stream3 = hold_dat.words[2];
   assign trunc   = hold_dat.trunc;

endmodule

// File: tb/tb_rle_line_encoder.sv
// Directed bench for rle_line_encoder: line patterns, backpressure, sop abort, reset.
module tb_rle_line_encoder;
   import rle_pkg::*;

   logic             CLK = 1'b0;
   logic             reset_n, in_valid, in_bit, in_sop, out_ready;
   logic [LEN_W-1:0] stream1, stream2, stream3;
   logic             out_valid, new_im, trunc;
   logic [7:0]       drop_cnt;

   int npass  = 0;
   int ntotal = 0;

   // pattern table: alternating segment lengths starting with first_bit
   int   seg   [4][5] = '{'{100, 200, 340, 0, 0}, '{50, 590, 0, 0, 0},
                          '{10, 10, 10, 10, 600}, '{639, 1, 0, 0, 0}};
   logic first_bit [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   int   exp_w [4][3]  = '{'{100, 200, 340}, '{0, 50, 590}, '{10, 10, 620}, '{639, 1, 0}};
   logic exp_t [4]     = '{1'b0, 1'b0, 1'b1, 1'b0};

   rle_line_encoder dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_sop    (in_sop),
      .out_ready (out_ready),
      .stream1   (stream1),
      .stream2   (stream2),
      .stream3   (stream3),
      .out_valid (out_valid),
      .new_im    (new_im),
      .trunc     (trunc),
      .drop_cnt  (drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic drive_pix(input logic b, input logic s);
      in_valid = 1'b1; in_bit = b; in_sop = s;
      @(posedge CLK); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_bit = 1'b0;
   endtask

   task automatic send_run(input int n, input logic b, input logic sop_first);
      for (int i = 0; i < n; i++) drive_pix(b, sop_first && i == 0);
   endtask

   task automatic test_reset;
      logic seen;
      reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      ntotal++;
      if ({out_valid, new_im, trunc, drop_cnt, stream1, stream2, stream3} !== '0)
         $display("FAIL reset_outputs: vld=%0b new_im=%0b trunc=%0b drop=%0d w=%0d,%0d,%0d, expected all 0",
                  out_valid, new_im, trunc, drop_cnt, stream1, stream2, stream3);
      else npass++;
      reset_n = 1'b1;
      @(posedge CLK); #1;
      seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         drive_pix(i % 3 == 0, 1'b0);
         seen |= out_valid | new_im;
      end
      ntotal++;
      if (seen !== 1'b0) $display("FAIL wait_sop_ignore: activity=%0b expected 0", seen);
      else npass++;
   endtask

   task automatic test_all_zero;
      drive_pix(1'b0, 1'b1);
      ntotal++;
      if (new_im !== 1'b1) $display("FAIL new_im_pulse: got %0b expected 1", new_im);
      else npass++;
      send_run(638, 1'b0, 1'b0);
      ntotal++;
      if (out_valid !== 1'b0) $display("FAIL early_valid: got %0b expected 0", out_valid);
      else npass++;
      drive_pix(1'b0, 1'b0);
      ntotal++;
      if ({out_valid, trunc, stream1, stream2, stream3} !== {1'b1, 1'b0, 11'd640, 11'd0, 11'd0})
         $display("FAIL all_zero: vld=%0b trunc=%0b w=%0d,%0d,%0d expected 1 0 640,0,0",
                  out_valid, trunc, stream1, stream2, stream3);
      else npass++;
      @(posedge CLK); #1;
      ntotal++;
      if (out_valid !== 1'b0) $display("FAIL valid_drop: got %0b expected 0", out_valid);
      else npass++;
   endtask

   task automatic test_patterns;
      logic b;
      for (int v = 0; v < 4; v++) begin
         b = first_bit[v];
         for (int s = 0; s < 5; s++) begin
            send_run(seg[v][s], b, 1'b0);
            b = ~b;
         end
         ntotal++;
         if ({out_valid, trunc, stream1, stream2, stream3} !==
             {1'b1, exp_t[v], LEN_W'(exp_w[v][0]), LEN_W'(exp_w[v][1]), LEN_W'(exp_w[v][2])})
            $display("FAIL pattern_%0d: vld=%0b trunc=%0b w=%0d,%0d,%0d expected 1 %0b %0d,%0d,%0d",
                     v, out_valid, trunc, stream1, stream2, stream3,
                     exp_t[v], exp_w[v][0], exp_w[v][1], exp_w[v][2]);
         else npass++;
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_run(100, 1'b0, 1'b0);
      send_run(540, 1'b1, 1'b0);
      ntotal++;
      if ({out_valid, stream1, stream2, stream3} !== {1'b1, 11'd100, 11'd540, 11'd0})
         $display("FAIL bp_first: vld=%0b w=%0d,%0d,%0d expected 1 100,540,0",
                  out_valid, stream1, stream2, stream3);
      else npass++;
      send_run(640, 1'b0, 1'b0);
      ntotal++;
      if ({out_valid, drop_cnt, stream1, stream2, stream3} !== {1'b1, 8'd1, 11'd100, 11'd540, 11'd0})
         $display("FAIL bp_hold: vld=%0b drop=%0d w=%0d,%0d,%0d expected 1 1 100,540,0",
                  out_valid, drop_cnt, stream1, stream2, stream3);
      else npass++;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      ntotal++;
      if ({out_valid, stream1, stream2, stream3} !== {1'b0, 11'd100, 11'd540, 11'd0})
         $display("FAIL bp_release: vld=%0b w=%0d,%0d,%0d expected 0 100,540,0",
                  out_valid, stream1, stream2, stream3);
      else npass++;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      send_run(640, 1'b1, 1'b0);
      ntotal++;
      if ({out_valid, stream1, stream2, stream3} !== {1'b1, 11'd0, 11'd640, 11'd0})
         $display("FAIL b2b_first: vld=%0b w=%0d,%0d,%0d expected 1 0,640,0",
                  out_valid, stream1, stream2, stream3);
      else npass++;
      send_run(320, 1'b1, 1'b0);
      send_run(319, 1'b0, 1'b0);
      out_ready = 1'b1;
      drive_pix(1'b0, 1'b0);
      ntotal++;
      if ({out_valid, drop_cnt, stream1, stream2, stream3} !== {1'b1, 8'd1, 11'd0, 11'd320, 11'd320})
         $display("FAIL b2b_same_cycle: vld=%0b drop=%0d w=%0d,%0d,%0d expected 1 1 0,320,320",
                  out_valid, drop_cnt, stream1, stream2, stream3);
      else npass++;
      @(posedge CLK); #1;
      ntotal++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drop: got %0b expected 0", out_valid);
      else npass++;
   endtask

   task automatic test_sop_abort;
      send_run(100, 1'b0, 1'b0);
      send_run(200, 1'b1, 1'b0);
      drive_pix(1'b0, 1'b1);
      ntotal++;
      if ({new_im, out_valid} !== 2'b10)
         $display("FAIL sop_abort_pulse: new_im=%0b vld=%0b expected 1 0", new_im, out_valid);
      else npass++;
      drive_pix(1'b0, 1'b0);
      ntotal++;
      if (new_im !== 1'b0) $display("FAIL new_im_width: got %0b expected 0", new_im);
      else npass++;
      send_run(318, 1'b0, 1'b0);
      send_run(319, 1'b1, 1'b0);
      ntotal++;
      if (out_valid !== 1'b0) $display("FAIL sop_partial_valid: got %0b expected 0", out_valid);
      else npass++;
      drive_pix(1'b1, 1'b0);
      ntotal++;
      if ({out_valid, trunc, stream1, stream2, stream3} !== {1'b1, 1'b0, 11'd320, 11'd320, 11'd0})
         $display("FAIL sop_restart: vld=%0b trunc=%0b w=%0d,%0d,%0d expected 1 0 320,320,0",
                  out_valid, trunc, stream1, stream2, stream3);
      else npass++;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_midline;
      logic seen;
      send_run(200, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      ntotal++;
      if ({out_valid, new_im, trunc, drop_cnt, stream1, stream2, stream3} !== '0)
         $display("FAIL midline_reset: vld=%0b drop=%0d w=%0d,%0d,%0d expected all 0",
                  out_valid, drop_cnt, stream1, stream2, stream3);
      else npass++;
      @(posedge CLK); #1;
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         drive_pix(1'b1, 1'b0);
         seen |= out_valid;
      end
      ntotal++;
      if (seen !== 1'b0) $display("FAIL post_reset_ignore: vld seen=%0b expected 0", seen);
      else npass++;
      send_run(640, 1'b1, 1'b1);
      ntotal++;
      if ({out_valid, stream1, stream2, stream3} !== {1'b1, 11'd0, 11'd640, 11'd0})
         $display("FAIL post_reset_line: vld=%0b w=%0d,%0d,%0d expected 1 0,640,0",
                  out_valid, stream1, stream2, stream3);
      else npass++;
   endtask

   initial begin
      test_reset;
      test_all_zero;
      test_patterns;
      test_backpressure;
      test_back_to_back;
      test_sop_abort;
      test_reset_midline;
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
